// File: rtl/vga_scanout.sv
// Raster read-out of the 160x120x3 playfield RAM onto a 640x480@60 VGA stream.
// Each playfield cell is shown as a 4x4 screen block; all outputs lag the counters by one pixel clock.
module vga_scanout #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SCALE_SHIFT = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic [14:0] address,
  input  logic [2:0]  q,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK,
  output logic        vblank
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS_C  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SS_C   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SE_C   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST_C = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS_C  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS_C   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SE_C   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST_C = 10'(V_TOTAL - 1);

  logic       r_pix_en;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank_n;
  logic       r_vblank;
  logic [2:0] r_rgb;

  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_active;
  logic       w_hs;
  logic       w_vs;
  logic [7:0] w_x;
  logic [6:0] w_y;

  always_comb begin
    w_h_next = r_h_cnt + 10'd1;
    w_v_next = r_v_cnt;
    if (r_h_cnt == H_LAST_C) begin
      w_h_next = '0;
      w_v_next = (r_v_cnt == V_LAST_C) ? 10'd0 : r_v_cnt + 10'd1;
    end
  end

  assign w_active = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
  assign w_hs     = !((r_h_cnt >= H_SS_C) && (r_h_cnt < H_SE_C));
  assign w_vs     = !((r_v_cnt >= V_SS_C) && (r_v_cnt < V_SE_C));

  // Outside the visible area the address is pinned to 0 so the RAM never sees X>159 or Y>119.
  assign w_x     = 8'(r_h_cnt >> SCALE_SHIFT);
  assign w_y     = 7'(r_v_cnt >> SCALE_SHIFT);
  assign address = w_active ? {w_x, w_y} : 15'd0;

  // Counters hold (h,v) for a full pixel period, so by the pix_en cycle q already
  // carries the cell for (h,v) and is captured alongside that pixel's sync/blank terms.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_pix_en  <= 1'b0;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
      r_vblank  <= 1'b0;
    end else begin
      r_pix_en <= ~r_pix_en;
      if (r_pix_en) begin
        r_h_cnt   <= w_h_next;
        r_v_cnt   <= w_v_next;
        r_hs      <= w_hs;
        r_vs      <= w_vs;
        r_blank_n <= w_active;
        r_rgb     <= w_active ? q : 3'b000;
        r_vblank  <= (w_v_next >= V_VIS_C);
      end
    end
  end

  assign VGA_R       = {8{r_rgb[2]}};
  assign VGA_G       = {8{r_rgb[1]}};
  assign VGA_B       = {8{r_rgb[0]}};
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = r_pix_en;
  assign vblank      = r_vblank;

endmodule
